mc_chroma_sched: RTL and testbench

Phase scheduler for the motion-compensation reconstruction path. It sequences one LCU through the MVD pass, U and V chroma interpolation, and the luma/U/V TQ passes. Independent phases overlap, so luma TQ runs under the MVD pass and chroma V interpolation runs under U-plane TQ. It sits between the system-level LCU start/done handshake and the chroma MC, TQ and MVD engines inside the MC top level.

---
 rtl/mc_chroma_sched.sv | 128 ++++++++++++
 tb/tb_mc_chroma_sched.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mc_chroma_sched.sv
// Sequences one LCU through MVD, chroma U/V interpolation and Y/U/V TQ, overlapping independent phases.
// All outputs are registered; every dependent launch follows its enabling done pulse by one cycle, and there is no backpressure.
module mc_chroma_sched #(
  parameter int MVD_CYC = 64,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_i,
  output logic       done_o,
  output logic       busy_o,
  output logic       mvd_access_o,
  output logic       chroma_start_o,
  output logic       chroma_sel_o,
  input  logic       chroma_done_i,
  output logic       tq_start_o,
  output logic [1:0] tq_sel_o,
  input  logic       tq_done_i
);

  typedef enum logic [2:0] {C_IDLE, C_WAIT_MVD, C_U, C_V, C_END} c_st_t;
  typedef enum logic [2:0] {T_IDLE, T_Y, T_WAIT_U, T_U, T_WAIT_V, T_V} t_st_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MVD_CYC - 1);

  c_st_t            c_st;
  t_st_t            t_st;
  logic [CNT_W-1:0] cnt;

  logic accept, win_close, u_passed, v_passed;

  // u_passed/v_passed include the done arriving this cycle so coincident events launch together.
  always_comb begin
    accept    = start_i & ~busy_o;
    win_close = mvd_access_o && (cnt == CNT_LAST);
    u_passed  = ((c_st == C_U) && chroma_done_i) || (c_st == C_V) || (c_st == C_END);
    v_passed  = ((c_st == C_V) && chroma_done_i) || (c_st == C_END);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_st           <= C_IDLE;
      t_st           <= T_IDLE;
      cnt            <= '0;
      done_o         <= 1'b0;
      busy_o         <= 1'b0;
      mvd_access_o   <= 1'b0;
      chroma_start_o <= 1'b0;
      chroma_sel_o   <= 1'b0;
      tq_start_o     <= 1'b0;
      tq_sel_o       <= 2'b00;
    end else begin
      chroma_start_o <= 1'b0;
      tq_start_o     <= 1'b0;
      done_o         <= 1'b0;

      if (mvd_access_o) begin
        if (cnt == CNT_LAST) mvd_access_o <= 1'b0;
        else                 cnt          <= cnt + 1'b1;
      end

      case (c_st)
        C_WAIT_MVD: if (win_close) begin
          chroma_start_o <= 1'b1;
          chroma_sel_o   <= 1'b0;
          c_st           <= C_U;
        end
        C_U: if (chroma_done_i) begin
          chroma_start_o <= 1'b1;
          chroma_sel_o   <= 1'b1;
          c_st           <= C_V;
        end
        C_V: if (chroma_done_i) c_st <= C_END;
        default: ;
      endcase

      case (t_st)
        T_Y: if (tq_done_i) begin
          if (u_passed) begin
            tq_start_o <= 1'b1;
            tq_sel_o   <= 2'b01;
            t_st       <= T_U;
          end else begin
            t_st <= T_WAIT_U;
          end
        end
        T_WAIT_U: if (u_passed) begin
          tq_start_o <= 1'b1;
          tq_sel_o   <= 2'b01;
          t_st       <= T_U;
        end
        T_U: if (tq_done_i) begin
          if (v_passed) begin
            tq_start_o <= 1'b1;
            tq_sel_o   <= 2'b10;
            t_st       <= T_V;
          end else begin
            t_st <= T_WAIT_V;
          end
        end
        T_WAIT_V: if (v_passed) begin
          tq_start_o <= 1'b1;
          tq_sel_o   <= 2'b10;
          t_st       <= T_V;
        end
        T_V: if (tq_done_i) begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          t_st   <= T_IDLE;
          c_st   <= C_IDLE;
        end
        default: ;
      endcase

      // Only reachable with both tracks idle, so it never races the track logic above.
      if (accept) begin
        busy_o       <= 1'b1;
        mvd_access_o <= 1'b1;
        cnt          <= '0;
        tq_start_o   <= 1'b1;
        tq_sel_o     <= 2'b00;
        c_st         <= C_WAIT_MVD;
        t_st         <= T_Y;
      end
    end
  end

endmodule

// File: tb/tb_mc_chroma_sched.sv
module tb_mc_chroma_sched;
  localparam int M = 64;

  logic       clk = 1'b0;
  logic       rstn, start_i, chroma_done_i, tq_done_i;
  logic       done_o, busy_o, mvd_access_o, chroma_start_o, chroma_sel_o, tq_start_o;
  logic [1:0] tq_sel_o;

  typedef struct {int cyc; int sel;} ev_t;
  ev_t q_ch[$];
  ev_t q_tq[$];
  int  q_dn[$];

  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  int mvd_lo = 1, mvd_hi = 0, busy_lo = 1, busy_hi = 0;

  mc_chroma_sched #(.MVD_CYC(M), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .done_o(done_o), .busy_o(busy_o),
    .mvd_access_o(mvd_access_o), .chroma_start_o(chroma_start_o), .chroma_sel_o(chroma_sel_o),
    .chroma_done_i(chroma_done_i), .tq_start_o(tq_start_o), .tq_sel_o(tq_sel_o),
    .tq_done_i(tq_done_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a launch or done pulse.
  always @(negedge clk) begin : mon
    ev_t e;
    int  d;
    if (rstn === 1'b1) begin
      if (chroma_start_o) begin
        if (q_ch.size() == 0) chk("chroma_extra", cyc, -1);
        else begin
          e = q_ch.pop_front();
          chk("chroma_cyc", cyc, e.cyc);
          chk("chroma_sel", int'(chroma_sel_o), e.sel);
        end
      end
      if (tq_start_o) begin
        if (q_tq.size() == 0) chk("tq_extra", cyc, -1);
        else begin
          e = q_tq.pop_front();
          chk("tq_cyc", cyc, e.cyc);
          chk("tq_sel", int'(tq_sel_o), e.sel);
        end
      end
      if (done_o) begin
        if (q_dn.size() == 0) chk("done_extra", cyc, -1);
        else begin
          d = q_dn.pop_front();
          chk("done_cyc", cyc, d);
        end
      end
      chk("mvd_access", int'(mvd_access_o), int'(cyc >= mvd_lo && cyc <= mvd_hi));
      chk("busy", int'(busy_o), int'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_mvd"}, int'(mvd_access_o), 0);
    chk({tag, "_cstart"}, int'(chroma_start_o), 0);
    chk({tag, "_csel"}, int'(chroma_sel_o), 0);
    chk({tag, "_tqstart"}, int'(tq_start_o), 0);
    chk({tag, "_tqsel"}, int'(tq_sel_o), 0);
  endtask

  task automatic do_abort();
    rstn = 1'b0; start_i = 1'b0; chroma_done_i = 1'b0; tq_done_i = 1'b0;
    #1;
    check_all_zero("abort");
    q_ch.delete(); q_tq.delete(); q_dn.delete();
    mvd_lo = 1; mvd_hi = 0; busy_lo = 1; busy_hi = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic int pick(input int lo, input int hi);
    if (lo > hi) return -1;
    return int'($urandom_range(hi, lo));
  endfunction

  // Reference model: each launch is one cycle after the later of its enabling events.
  // Called in the start cycle; returns in the done_o cycle (or after an abort).
  task automatic do_run(input int dy, input int dcu, input int dcv, input int dtu, input int dtv,
                        input bit co1, input bit co2, input bit noise, input int abort_off);
    int s, cu, cdu, tdy, cv, cdv, tqu, tdu, tqv, tdv, dn;
    int sp_c1, sp_c2, sp_t1, sp_t2, bp1, bp2;
    s   = cyc;
    cu  = s + M + 1;
    cdu = cu + dcu;
    tdy = co1 ? cdu : s + 1 + dy;
    cv  = cdu + 1;
    cdv = cv + dcv;
    tqu = ((tdy > cdu) ? tdy : cdu) + 1;
    tdu = (co2 && cdv > tqu) ? cdv : tqu + dtu;
    tqv = ((tdu > cdv) ? tdu : cdv) + 1;
    tdv = tqv + dtv;
    dn  = tdv + 1;
    q_tq.push_back('{s + 1, 0});
    q_ch.push_back('{cu, 0});
    q_ch.push_back('{cv, 1});
    q_tq.push_back('{tqu, 1});
    q_tq.push_back('{tqv, 2});
    q_dn.push_back(dn);
    mvd_lo = s + 1; mvd_hi = s + M;
    busy_lo = s + 1; busy_hi = dn - 1;
    sp_c1 = pick(s + 1, s + M);
    sp_c2 = pick(cdv + 1, dn - 1);
    sp_t1 = pick(tdy + 1, tqu - 1);
    sp_t2 = pick(tdu + 1, tqv - 1);
    bp1   = pick(s + 1, dn - 1);
    bp2   = pick(s + 1, dn - 1);
    for (int t = s; t < dn; t++) begin
      if (abort_off > 0 && t == s + abort_off) begin
        do_abort();
        return;
      end
      start_i       = (t == s) || (noise && (t == bp1 || t == bp2));
      chroma_done_i = (t == cdu) || (t == cdv) || (noise && (t == sp_c1 || t == sp_c2));
      tq_done_i     = (t == tdy) || (t == tdu) || (t == tdv) || (noise && (t == sp_t1 || t == sp_t2));
      @(posedge clk); #1;
    end
    start_i = 1'b0; chroma_done_i = 1'b0; tq_done_i = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start_i = 1'b0; chroma_done_i = 1'b0; tq_done_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_all_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic run: Y done +40, U done +100, V done +150, TQ U/V done +120/+200.
    do_run(39, 35, 49, 19, 49, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) begin @(posedge clk); #1; end
    // Late TQ-Y at +300 holds TQ-U until +301.
    do_run(299, 35, 49, 19, 49, 1'b0, 1'b0, 1'b0, 0);
    // Started in the done cycle; both coincident-event cases.
    do_run(10, 20, 20, 20, 20, 1'b1, 1'b1, 1'b0, 0);
    // Reset 70 cycles into a run with both sel outputs at 1.
    do_run(5, 2, 30, 30, 30, 1'b0, 1'b0, 1'b0, 70);
    do_run(39, 35, 49, 19, 49, 1'b0, 1'b0, 1'b1, 0);

    for (int i = 0; i < 16; i++) begin
      do_run(int'($urandom_range(150, 1)), int'($urandom_range(40, 1)), int'($urandom_range(40, 1)),
             int'($urandom_range(40, 1)), int'($urandom_range(40, 1)),
             ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0), 1'b1, 0);
      if ($urandom_range(1, 0) == 1) begin
        repeat (int'($urandom_range(5, 1))) begin @(posedge clk); #1; end
      end
    end

    repeat (5) begin @(posedge clk); #1; end
    chk("chroma_missing", q_ch.size(), 0);
    chk("tq_missing", q_tq.size(), 0);
    chk("done_missing", q_dn.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
